// File: rtl/alu_pkg.sv
// Shared mode codes, flag bit positions and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] MODE_ADD  = 4'b0000;
  localparam logic [3:0] MODE_SUB  = 4'b0001;
  localparam logic [3:0] MODE_A    = 4'b0010;
  localparam logic [3:0] MODE_B    = 4'b0011;
  localparam logic [3:0] MODE_AND  = 4'b0100;
  localparam logic [3:0] MODE_OR   = 4'b0101;
  localparam logic [3:0] MODE_XOR  = 4'b0110;
  localparam logic [3:0] MODE_NOTA = 4'b0111;
  localparam logic [3:0] MODE_NOTB = 4'b1000;
  localparam logic [3:0] MODE_NAND = 4'b1001;
  localparam logic [3:0] MODE_NOR  = 4'b1010;
  localparam logic [3:0] MODE_XNOR = 4'b1011;
  localparam logic [3:0] MODE_SHL  = 4'b1100;
  localparam logic [3:0] MODE_SHR  = 4'b1101;
  localparam logic [3:0] MODE_CAT  = 4'b1110;
  localparam logic [3:0] MODE_MUL  = 4'b1111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic {IDLE, MUL} state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between operand fetch, the ALU and writeback.
interface alu_seq_if #(parameter int WIDTH = 4) ();
  logic                 i_valid;
  logic                 o_ready;
  logic [3:0]           i_mode;
  logic                 i_use_carry;
  logic [WIDTH-1:0]     i_op1;
  logic [WIDTH-1:0]     i_op2;
  logic                 o_valid;
  logic                 i_ready;
  logic [2*WIDTH-1:0]   o_result;
  logic [3:0]           o_Flags;

  modport slave (
    input  i_valid, i_mode, i_use_carry, i_op1, i_op2, i_ready,
    output o_ready, o_valid, o_result, o_Flags
  );

  modport master (
    output i_valid, i_mode, i_use_carry, i_op1, i_op2, i_ready,
    input  o_ready, o_valid, o_result, o_Flags
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per clock, WIDTH clocks after start.
module alu_seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  logic                 r_busy;
  logic [WIDTH-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  // The product is presented combinationally on the last step so the top can load it that edge.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = w_acc_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= WIDTH'(WIDTH - 1);
      r_mplier <= i_b;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-generic ALU with valid/ready handshake, stored carry and multi-cycle multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  alu_seq_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  state_t             r_state, w_state_nxt;
  logic               r_valid;
  logic [W2-1:0]      r_result;
  logic [3:0]         r_flags;

  logic [WIDTH-1:0]   w_a, w_b, w_lo;
  logic [WIDTH:0]     w_sum, w_diff;
  logic               w_cin, w_ready, w_accept, w_mul_start, w_mul_done;
  logic               w_hi, w_v, w_c;
  logic [W2-1:0]      w_res, w_product;
  logic               w_load, w_ld_hi, w_ld_v, w_ld_c;
  logic [W2-1:0]      w_ld_res;
  logic [3:0]         w_ld_flg;

  assign w_a    = bus.i_op1;
  assign w_b    = bus.i_op2;
  assign w_cin  = bus.i_use_carry & r_flags[FLAG_C];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b} - {{WIDTH{1'b0}}, w_cin};

  assign w_ready     = (r_state == IDLE) && (!r_valid || bus.i_ready);
  assign w_accept    = bus.i_valid && w_ready;
  assign w_mul_start = w_accept && (bus.i_mode == MODE_MUL) && MUL_EN;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_mul_start),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // Single-cycle datapath; MUL falls through to zero here and is overridden when the multiplier finishes.
  always_comb begin
    w_lo  = '0;
    w_res = '0;
    w_hi  = 1'b0;
    w_v   = 1'b0;
    w_c   = 1'b0;
    case (bus.i_mode)
      MODE_ADD: begin
        w_lo = w_sum[WIDTH-1:0];
        w_c  = w_sum[WIDTH];
        w_v  = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      MODE_SUB: begin
        w_lo = w_diff[WIDTH-1:0];
        w_c  = w_diff[WIDTH];
        w_v  = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      MODE_A:    w_lo = w_a;
      MODE_B:    w_lo = w_b;
      MODE_AND:  w_lo = w_a & w_b;
      MODE_OR:   w_lo = w_a | w_b;
      MODE_XOR:  w_lo = w_a ^ w_b;
      MODE_NOTA: w_lo = ~w_a;
      MODE_NOTB: w_lo = ~w_b;
      MODE_NAND: w_lo = ~(w_a & w_b);
      MODE_NOR:  w_lo = ~(w_a | w_b);
      MODE_XNOR: w_lo = ~(w_a ^ w_b);
      MODE_SHL: begin
        w_lo = {w_a[WIDTH-2:0], 1'b0};
        w_c  = w_a[WIDTH-1];
      end
      MODE_SHR: begin
        w_lo = {1'b0, w_a[WIDTH-1:1]};
        w_c  = w_a[0];
      end
      MODE_CAT: w_hi = 1'b1;
      MODE_MUL: w_hi = 1'b1;
      default:  w_lo = '0;
    endcase
    if (bus.i_mode == MODE_CAT) w_res = {w_a, w_b};
    else if (!w_hi)             w_res = {{WIDTH{1'b0}}, w_lo};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ld_res    = w_res;
    w_ld_hi     = w_hi;
    w_ld_v      = w_v;
    w_ld_c      = w_c;
    case (r_state)
      IDLE: begin
        if (w_mul_start)   w_state_nxt = MUL;
        else if (w_accept) w_load      = 1'b1;
      end
      MUL: begin
        if (w_mul_done) begin
          w_state_nxt = IDLE;
          w_load      = 1'b1;
          w_ld_res    = w_product;
          w_ld_hi     = 1'b1;
          w_ld_v      = 1'b0;
          w_ld_c      = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ld_flg         = '0;
    w_ld_flg[FLAG_Z] = (w_ld_res == '0);
    w_ld_flg[FLAG_N] = w_ld_hi ? w_ld_res[W2-1] : w_ld_res[WIDTH-1];
    w_ld_flg[FLAG_V] = w_ld_v;
    w_ld_flg[FLAG_C] = w_ld_c;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_result <= w_ld_res;
      r_flags  <= w_ld_flg;
    end else if (bus.i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign bus.o_ready  = w_ready;
  assign bus.o_valid  = r_valid;
  assign bus.o_result = r_result;
  assign bus.o_Flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH=4, with a second MUL_EN=0 instance.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq_if #(.WIDTH(W)) bus0 ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flg;
    logic [7:0] lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, output int elat);
    exp_t e;
    elat = -1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, observed %0h", tag, bus.o_result);
    end else begin
      e = sb.pop_front();
      elat = int'(e.lat);
      check({tag, "_res"}, 32'(bus.o_result), 32'(e.res));
      check({tag, "_flg"}, 32'(bus.o_Flags), 32'(e.flg));
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] mode, input logic uc,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] er, input logic [3:0] ef, input int elat_in);
    int lat;
    int elat;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_mode = mode; bus.i_use_carry = uc;
    bus.i_op1 = a; bus.i_op2 = b;
    sb.push_back('{res: er, flg: ef, lat: 8'(elat_in)});
    for (int k = 0; k < 20 && !bus.o_ready; k++) @(negedge clk);
    check({tag, "_rdy"}, 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.o_valid && lat < 20) begin
      check({tag, "_busy"}, 32'(bus.o_ready), 32'd0);
      lat++;
      @(negedge clk);
    end
    pop_cmp(tag, elat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dummy;
    bus.i_valid = 1'b0; bus.i_mode = '0; bus.i_use_carry = 1'b0;
    bus.i_op1 = '0; bus.i_op2 = '0; bus.i_ready = 1'b1;
    bus0.i_valid = 1'b0; bus0.i_mode = '0; bus0.i_use_carry = 1'b0;
    bus0.i_op1 = '0; bus0.i_op2 = '0; bus0.i_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_res",   32'(bus.o_result), 32'd0);
    check("rst_flg",   32'(bus.o_Flags), 32'd0);
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    rst_n = 1'b1;

    // Flags column order is {C,V,N,Z}.
    run_op("add_7_9",   MODE_ADD, 1'b1, 4'h7, 4'h9, 8'h00, 4'b1001, 1);
    run_op("add_cin",   MODE_ADD, 1'b1, 4'h2, 4'h3, 8'h06, 4'b0000, 1);
    run_op("add_f_1",   MODE_ADD, 1'b0, 4'hF, 4'h1, 8'h00, 4'b1001, 1);
    run_op("add_nocin", MODE_ADD, 1'b0, 4'h2, 4'h3, 8'h05, 4'b0000, 1);
    run_op("sub_3_5",   MODE_SUB, 1'b0, 4'h3, 4'h5, 8'h0E, 4'b1010, 1);
    run_op("sub_8_1",   MODE_SUB, 1'b0, 4'h8, 4'h1, 8'h07, 4'b0100, 1);
    run_op("and",       MODE_AND, 1'b0, 4'hC, 4'hA, 8'h08, 4'b0010, 1);
    run_op("concat",    MODE_CAT, 1'b0, 4'hA, 4'h5, 8'hA5, 4'b0010, 1);
    run_op("shl",       MODE_SHL, 1'b0, 4'h9, 4'h0, 8'h02, 4'b1000, 1);
    run_op("shr",       MODE_SHR, 1'b0, 4'h3, 4'h0, 8'h01, 4'b1000, 1);
    run_op("nor",       MODE_NOR, 1'b0, 4'hF, 4'h0, 8'h00, 4'b0001, 1);
    run_op("mul_f_f",   MODE_MUL, 1'b0, 4'hF, 4'hF, 8'hE1, 4'b0010, 5);
    run_op("mul_7_3",   MODE_MUL, 1'b0, 4'h7, 4'h3, 8'h15, 4'b0000, 5);
    run_op("mul_0_5",   MODE_MUL, 1'b0, 4'h0, 4'h5, 8'h00, 4'b0001, 5);

    // MUL_EN=0 build: mode 1111 is a single-cycle zero.
    @(negedge clk);
    bus0.i_valid = 1'b1; bus0.i_mode = MODE_MUL; bus0.i_op1 = 4'hF; bus0.i_op2 = 4'hF;
    @(posedge clk);
    #1 bus0.i_valid = 1'b0;
    @(negedge clk);
    check("nomul_valid", 32'(bus0.o_valid), 32'd1);
    check("nomul_res",   32'(bus0.o_result), 32'd0);
    check("nomul_flg",   32'(bus0.o_Flags), 32'b0001);

    // Backpressure: XOR result held while a queued ADD waits.
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_mode = MODE_XOR; bus.i_use_carry = 1'b0;
    bus.i_op1 = 4'hA; bus.i_op2 = 4'h5;
    sb.push_back('{res: 8'h0F, flg: 4'b0010, lat: 8'd1});
    check("bp_rdy_in", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
    check("bp_valid", 32'(bus.o_valid), 32'd1);
    bus.i_valid = 1'b1; bus.i_mode = MODE_ADD; bus.i_op1 = 4'h1; bus.i_op2 = 4'h2;
    sb.push_back('{res: 8'h03, flg: 4'b0000, lat: 8'd1});
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_res", 32'(bus.o_result), 32'h0F);
      check("bp_stall",    32'(bus.o_ready), 32'd0);
      check("bp_hold_v",   32'(bus.o_valid), 32'd1);
      @(negedge clk);
    end
    bus.i_ready = 1'b1;
    #1;
    check("bp_rdy_release", 32'(bus.o_ready), 32'd1);
    pop_cmp("bp_xor", dummy);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 32'(bus.o_valid), 32'd1);
    pop_cmp("bp_next", dummy);

    // Reset in the middle of a multiply, with a stored carry beforehand.
    run_op("pre_carry", MODE_ADD, 1'b0, 4'hF, 4'h1, 8'h00, 4'b1001, 1);
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_mode = MODE_MUL; bus.i_op1 = 4'h9; bus.i_op2 = 4'h7;
    check("rmul_rdy", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rmul_valid", 32'(bus.o_valid), 32'd0);
    check("rmul_res",   32'(bus.o_result), 32'd0);
    check("rmul_flg",   32'(bus.o_Flags), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rmul_no_stale", 32'(bus.o_valid), 32'd0);
    end
    run_op("post_rst_add", MODE_ADD, 1'b1, 4'h1, 4'h1, 8'h02, 4'b0000, 1);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 4-bit ALU.
- Adds a WIDTH-generic datapath and a valid/ready handshake on input and output.
- Keeps the carry flag in an internal register so multi-word add/sub chains run without external feedback.
- Adds a multi-cycle shift-add unsigned multiply. Sits between the operand fetch stage and the result writeback stage of the datapath.

Parameters:
- WIDTH, 4, operand width in bits (legal: 2 to 32).
- MUL_EN, 1, 1 = mode 4'b1111 is a multi-cycle multiply; 0 = mode 4'b1111 returns zero in a single cycle.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  operation request.
- o_ready  out  1  block can accept a request this cycle.
- i_mode  in  4  operation select (encoding below).
- i_use_carry  in  1  1 = carry/borrow-in comes from the stored C flag; 0 = carry-in is 0.
- i_op1  in  WIDTH  operand A.
- i_op2  in  WIDTH  operand B.
- o_valid  out  1  result/flags valid.
- i_ready  in  1  downstream consumes the result.
- o_result  out  2*WIDTH  registered result.
- o_Flags  out  4  registered flags: [0] Z, [1] N, [2] V, [3] C.

Behaviour:
- Reset (i_rst_n=0 at an edge): state IDLE; o_valid=0; o_result=0; o_Flags=0 (including the stored C); o_ready=1 once out of reset. Reset wins over every other event, including mid-multiply; no partial result is ever emitted.
- Accept condition: i_valid && o_ready. o_ready = (state==IDLE) && (!o_valid || i_ready). Operands and mode are latched on accept. Inputs are ignored at all other times.
- Output hold: o_result and o_Flags stay stable while o_valid=1 && i_ready=0. o_valid clears on the edge where i_ready=1 unless a new result loads on that same edge. Back-to-back single-cycle ops sustain 1 op per cycle.
- Single-cycle ops: accept at edge t. o_valid=1 with the result after edge t (latency 1).
- Mode encoding. Upper WIDTH bits of o_result are zero unless stated.
  - 0000 ADD: A+B+cin.
  - 0001 SUB: A-B-cin.
  - 0010 A.
  - 0011 B.
  - 0100 AND.
  - 0101 OR.
  - 0110 XOR.
  - 0111 ~A.
  - 1000 ~B.
  - 1001 NAND.
  - 1010 NOR.
  - 1011 XNOR.
  - 1100 SHL A by 1.
  - 1101 SHR A by 1 (logical).
  - 1110 CONCAT {A,B} (full 2*WIDTH).
  - 1111 MUL A*B unsigned (full 2*WIDTH), or zero when MUL_EN=0.
- MUL flow (MUL_EN=1): IDLE→MUL on accept at edge t.
  - One partial product per edge, t+1 through t+WIDTH.
  - A WIDTH-bit step counter runs WIDTH-1 down to 0.
  - On the final step: MUL→IDLE, o_valid=1, product loaded.
  - o_ready=0 throughout MUL.
  - Latency: WIDTH+1 edges from accept to o_valid.
- Flags are computed on the same edge as the result and loaded only when a result loads.
  - Z: o_result == 0 across all 2*WIDTH bits.
  - N: o_result[2*WIDTH-1] for CONCAT/MUL; o_result[WIDTH-1] for all other modes.
  - V: ADD/SUB only. Signed overflow of the WIDTH-bit result (ADD: A,B same sign and result sign differs; SUB: A,B differ in sign and result sign differs from A). 0 otherwise.
  - C:
    - ADD: carry out of bit WIDTH-1.
    - SUB: borrow (A < B+cin, unsigned).
    - SHL: A[WIDTH-1].
    - SHR: A[0].
    - All other modes: C is cleared to 0.
- cin = i_use_carry & o_Flags[3], sampled at accept. Same-cycle hazard: if a result loads on the accept edge, cin uses the previous stored C. Chained carries therefore need a 1-cycle gap or a stalled accept.
- Undefined i_mode values cannot occur (4-bit fully decoded).

Decomposition:
- Package alu_pkg holds:
  - localparams for the 16 mode codes (MODE_ADD … MODE_MUL);
  - flag indices FLAG_Z=0, FLAG_N=1, FLAG_V=2, FLAG_C=3;
  - the state enum {IDLE, MUL}.
- One sub-module, alu_seq_mul: WIDTH-parametrised iterative shift-add multiplier with start/done. Keeps the top-level FSM and handshake separate from the datapath.

Test Plan (WIDTH=4):
- ADD 7+9, use_carry=0 → result 0x00, Flags Z=1 N=0 V=0 C=1, o_valid one edge after accept.
- Next op ADD 2+3, use_carry=1, accepted one cycle after the previous result is stored → result 0x06, C=0. Repeat with use_carry=0 → 0x05.
- SUB 3-5, use_carry=0 → result 0x0E, N=1, C=1, V=0. SUB 0x8-0x1 → 0x07, V=1.
- MUL 15*15 → o_ready=0 for 4 cycles, o_valid after 5 edges, result 0xE1, N=1, Z=0. MUL_EN=0 build: MUL returns 0x00 after 1 edge with Z=1.
- Backpressure: i_ready=0 for 3 cycles after an XOR 0xA^0x5 → o_result=0x0F held stable, o_ready=0. i_ready=1 → next queued op is accepted on that same edge.
- Reset asserted 2 cycles into MUL 9*7 → o_valid=0, o_Flags=0, o_result=0 after that edge. A following ADD 1+1 returns 0x02 with no stale product and no stale carry.
